// File: rtl/miriscv_dmem_resp_if.sv
// rtl/miriscv_dmem_resp_if.sv - LSU data port between the miriscv core and its data memory responder
interface miriscv_dmem_resp_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  rdata_o, stall_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output rdata_o, stall_o, err_o
  );
endinterface

// File: rtl/miriscv_dmem_resp.sv
// rtl/miriscv_dmem_resp.sv - word-organised data RAM with programmable wait states for the miriscv LSU
module miriscv_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic               clk_i,
  input logic               arstn_i,
  miriscv_dmem_resp_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [3:0]  cap_be;
  logic [29:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        start;
  logic        commit;
  logic        c_we;
  logic [3:0]  c_be;
  logic [29:0] c_addr;
  logic [31:0] c_wdata;
  logic [29:0] word_diff;
  logic        in_range;
  logic [AW-1:0] idx;

  // With zero latency the access commits on the accepting edge, straight from the bus.
  always_comb begin
    start     = (state == IDLE) && bus.req_i;
    commit    = arstn_i && ((start && (LATENCY == 0)) || ((state == BUSY) && (cnt == 4'd1)));
    c_we      = (state == IDLE) ? bus.we_i         : cap_we;
    c_be      = (state == IDLE) ? bus.be_i         : cap_be;
    c_addr    = (state == IDLE) ? bus.addr_i[31:2] : cap_addr;
    c_wdata   = (state == IDLE) ? bus.wdata_i      : cap_wdata;
    word_diff = c_addr - BASE_ADDR[31:2];
    in_range  = word_diff < 30'(DEPTH_WORDS);
    idx       = word_diff[AW-1:0];
  end

  assign bus.stall_o = (state == BUSY) || start;
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_be    <= 4'd0;
      cap_addr  <= 30'd0;
      cap_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= commit && !in_range;
      if (commit && !c_we)
        rdata_q <= in_range ? mem[idx] : 32'h0;
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            cap_we    <= bus.we_i;
            cap_be    <= bus.be_i;
            cap_addr  <= bus.addr_i[31:2];
            cap_wdata <= bus.wdata_i;
            cnt       <= 4'(LATENCY);
            state     <= (LATENCY == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM contents survive reset; an aborted access never reaches a commit edge.
  always_ff @(posedge clk_i) begin
    if (commit && c_we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b])
          mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: doc/miriscv_dmem_resp.md
Name: miriscv_dmem_resp

Overview:
Data-memory responder serving the miriscv core's LSU port, i.e. the target side of the data_req/data_we/data_be/data_addr/data_wdata/data_rdata interface. It holds a word-organised RAM and inserts a programmable number of wait states. It drives the core's stall input while an access is in flight and returns read data in the first unstalled cycle. It sits beside the core in the top level and is used both as the real data RAM and as the latency stress model in verification.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, 4..65536
LATENCY, 2, extra wait cycles per access; 0..15
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4

Ports:
clk_i  input  1  clock; all state on rising edge
arstn_i  input  1  asynchronous active-low reset
req_i  input  1  access request (core data_req_o)
we_i  input  1  1 = write, 0 = read
be_i  input  4  byte enables; bit n selects wdata_i[8n+7:8n]
addr_i  input  32  byte address; bits [1:0] ignored
wdata_i  input  32  write data
rdata_o  output  32  read data (to core data_rdata_i)
stall_o  output  1  hold core (to core stall_i)
err_o  output  1  out-of-range access flag, 1-cycle pulse

Behaviour:
- Reset (arstn_i low, async): state IDLE, stall_o=0, rdata_o=0, err_o=0, captured-request registers cleared. RAM contents are not reset. Reset mid-access aborts it and the pending write is not committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE, req_i=1: stall_o=1 combinationally in the same cycle. On that edge, capture we_i, be_i, addr_i and wdata_i and load cnt=LATENCY. Go to BUSY if LATENCY>0, else commit and go to DONE.
- IDLE, req_i=0: stall_o=0, stay in IDLE.
- BUSY: stall_o=1; cnt decrements each edge. On the edge where cnt==1, commit the access and go to DONE. Inputs are ignored, so a req_i drop while BUSY does not cancel the access.
- Commit, in-range read: rdata_o <= RAM[idx].
- Commit, in-range write: RAM[idx] byte n <= captured wdata byte n for each be bit set. rdata_o is unchanged. be=4'b0000 writes nothing.
- idx = (addr - BASE_ADDR) >> 2. In-range means 0 <= addr-BASE_ADDR < DEPTH_WORDS*4, compared unsigned on the 32-bit difference.
- Commit, out-of-range access: write dropped, rdata_o <= 32'h0, err_o=1 during the DONE cycle.
- DONE: stall_o=0, rdata_o valid, err_o as computed; next state is always IDLE. req_i is ignored in DONE because the core still presents the same instruction. A new request is accepted in the following IDLE cycle.
- Latency: stall_o is high for exactly LATENCY+1 cycles, then DONE. rdata_o holds its value until the next read commit.
- Back-to-back accesses: the pattern IDLE(stall) / BUSY x LATENCY / DONE repeats, giving at most one access per LATENCY+2 cycles.
- Read after write to the same word: the read returns the merged new data, because the write committed in an earlier cycle.
- rdata_o, err_o and the state are registered. stall_o = (state==BUSY) | (state==IDLE & req_i).

Test Plan:
- Reset with LATENCY=2: drive arstn_i=0 mid-cycle -> rdata_o=0, stall_o=0 and err_o=0 immediately. Release it, hold req_i=0 -> stall_o stays 0.
- Full write then read: write addr 0x10, be=4'hF, wdata=32'hDEAD_BEEF -> stall_o high 3 cycles, then DONE. Read addr 0x10 -> stall_o high 3 cycles, rdata_o=32'hDEAD_BEEF in the DONE cycle.
- Byte-enable merge: preload 0x20=32'h1122_3344, write be=4'b0101 with wdata=32'hAABB_CCDD -> subsequent read of 0x20 returns 32'h11BB_33DD.
- LATENCY=0 instance: read addr 0x4 -> stall_o high for 1 cycle only, data valid in the next cycle. A continuous req_i over two instructions gives the pattern stall 1,0,1,0.
- Out of range (DEPTH_WORDS=1024, BASE_ADDR=0): write to 0x1000, then read 0x1000 -> write dropped, read rdata_o=0, err_o pulses 1 cycle in each DONE. Word 0 is not corrupted.
- Abort and protocol edge cases: write 0x30 with arstn_i pulsed low while BUSY -> a later read of 0x30 returns the old value and the FSM is in IDLE. Separately, drop req_i during BUSY -> the access still completes and stall_o is released after LATENCY+1 cycles.
